vector_add_sequencer: RTL and testbench

//   Sequences a stream of 16-bit operand pairs through a shared element adder.

---
 rtl/vector_add_sequencer.sv | 132 +++++++++++++
 tb/tb_vector_add_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_add_sequencer.sv
// Streams operand pairs through one DW-bit adder and packs LANES sums per
// output word, first sum in the most-significant lane.
module vector_add_sequencer #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_a,
  input  logic [DW-1:0]         in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  out_last
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic [LEN_W-1:0]    r_rem;
  logic [IDX_W-1:0]    r_idx;
  logic [LANES*DW-1:0] r_part;
  logic                r_out_valid;
  logic [LANES*DW-1:0] r_out_data;
  logic                r_out_last;
  logic                r_done;

  logic [DW-1:0]       w_sum;
  logic [LANES*DW-1:0] w_word;
  logic [LEN_W-1:0]    w_rem_nx;
  logic                w_acc;
  logic                w_fin;
  logic                w_full;
  logic                w_emit;
  logic                w_hs;

  assign w_sum    = in_a + in_b;
  assign w_acc    = (r_state == S_RUN) && in_valid && !r_out_valid;
  assign w_rem_nx = r_rem - LEN_W'(1);
  assign w_fin    = (w_rem_nx == '0);
  assign w_full   = (r_idx == IDX_W'(LANES - 1));
  assign w_emit   = w_acc && (w_full || w_fin);
  assign w_hs     = r_out_valid && out_ready;

  // Partial word with the incoming sum dropped into the current lane.
  always_comb begin
    w_word = r_part;
    for (int k = 0; k < LANES; k++) begin
      if (int'(r_idx) == k) begin
        w_word[(LANES-k)*DW-1 -: DW] = w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_idx       <= '0;
      r_part      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_rem   <= len;
              r_idx   <= '0;
              r_part  <= '0;
              r_state <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_acc) begin
            r_rem <= w_rem_nx;
            if (w_emit) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_word;
              r_out_last  <= w_fin;
              r_part      <= '0;
              r_idx       <= '0;
            end else begin
              r_part <= w_word;
              r_idx  <= r_idx + IDX_W'(1);
            end
            if (w_fin) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Only the final word can be pending here.
          if (w_hs && r_out_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign in_ready  = (r_state == S_RUN) && !r_out_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_vector_add_sequencer.sv
// Scoreboard bench for vector_add_sequencer: directed cases plus random jobs
// against a plain-arithmetic packing model.
module tb_vector_add_sequencer;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int LEN_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic                busy;
  logic                done;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_a;
  logic [DW-1:0]       in_b;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] out_data;
  logic                out_last;

  vector_add_sequencer #(.DW(DW), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DW-1:0] data;
    logic                last;
  } word_t;

  word_t         sb[$];
  logic [63:0]   got[$];
  logic [DW-1:0] ga[$];
  logic [DW-1:0] gb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int len0_cyc = -1;
  bit rdy_force = 1'b1;
  bit rdy_val = 1'b1;
  logic exp_done_next = 1'b0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic prev_last = 1'b0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void fail_now(string name);
    checks++;
    $display("FAIL %s: timed out", name);
  endfunction

  // Reference: sums mod 2^DW, LANES per word, first sum in MS lane.
  function automatic void model_push(int n);
    for (int w = 0; w * LANES < n; w++) begin
      word_t e;
      e.data = '0;
      for (int k = 0; k < LANES; k++) begin
        int idx = w * LANES + k;
        if (idx < n) begin
          int s = (int'(ga[idx]) + int'(gb[idx])) % 65536;
          e.data = e.data | (64'(s) << ((LANES - 1 - k) * DW));
        end
      end
      e.last = ((w + 1) * LANES >= n);
      sb.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_force) out_ready = rdy_val;
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_done_next = 1'b0;
      prev_stall = 1'b0;
    end else begin
      logic exp_done;
      exp_done = exp_done_next || (cyc == len0_cyc);
      exp_done_next = 1'b0;
      if (done || exp_done) chk("done", 64'(done), 64'(exp_done));
      if (done) chk("busy at done", 64'(busy), 64'd0);
      if (prev_stall) begin
        chk("hold valid", 64'(out_valid), 64'd1);
        chk("hold data", out_data, prev_data);
        chk("hold last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid) chk("in_ready while out_valid", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL word: unexpected word %h", out_data);
        end else begin
          word_t e;
          e = sb.pop_front();
          chk("word data", out_data, e.data);
          chk("word last", 64'(out_last), 64'(e.last));
          got.push_back(out_data);
          if (e.last) exp_done_next = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || sb.size() != 0) && g < 3000);
    if (busy || sb.size() != 0) fail_now("job completion");
    @(negedge clk);
  endtask

  task automatic run_job(input int n, input bit mid_start,
                         input int rst_after, input bit gaps);
    wait_idle();
    @(posedge clk);
    #1;
    if (rst_after < 0) model_push(n);
    start = 1'b1;
    len = LEN_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    len = LEN_W'($urandom);
    if (n == 0) len0_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bit acc;
      if (i == rst_after) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        return;
      end
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_a = DW'($urandom);
        in_b = DW'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_a = ga[i];
      in_b = gb[i];
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        g++;
      end while (!acc && g < 1000);
      if (!acc) fail_now("pair accept");
      in_valid = 1'b0;
      in_a = DW'($urandom);
      in_b = DW'($urandom);
      if (mid_start && i == 0) begin
        start = 1'b1;
        len = LEN_W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_t1();
    ga = '{16'd1, 16'd3, 16'd5, 16'd7};
    gb = '{16'd2, 16'd4, 16'd6, 16'd8};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1
    load_t1();
    run_job(4, 1'b0, -1, 1'b0);
    wait_idle();
    chk("T1 word", got[got.size()-1], 64'h0003_0007_000B_000F);

    // T2 with a start pulse in the middle of the job
    ga = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    gb = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    run_job(6, 1'b1, -1, 1'b0);
    wait_idle();
    chk("T2 word0", got[got.size()-2], 64'h0001_0002_0003_0004);
    chk("T2 word1", got[got.size()-1], 64'h0005_0006_0000_0000);

    // T3 carry dropped
    ga = '{16'hFFFF};
    gb = '{16'h0002};
    run_job(1, 1'b0, -1, 1'b0);
    wait_idle();
    chk("T3 word", got[got.size()-1], 64'h0001_0000_0000_0000);

    // T4 output backpressure
    rdy_force = 1'b1;
    rdy_val = 1'b0;
    load_t1();
    fork
      run_job(4, 1'b0, -1, 1'b0);
      begin
        int g = 0;
        while (!out_valid && g < 200) begin
          @(negedge clk);
          g++;
        end
        if (!out_valid) fail_now("T4 out_valid");
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("T4 stall valid", 64'(out_valid), 64'd1);
          chk("T4 stall in_ready", 64'(in_ready), 64'd0);
          chk("T4 stall data", out_data, 64'h0003_0007_000B_000F);
        end
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
      end
    join
    wait_idle();

    // T5 zero-length job
    run_job(0, 1'b0, -1, 1'b0);
    wait_idle();

    // T6 reset mid-job, then a clean T1
    for (int i = 0; i < 4; i++) begin
      ga[i] = DW'($urandom);
      gb[i] = DW'($urandom);
    end
    run_job(4, 1'b0, 2, 1'b0);
    load_t1();
    run_job(4, 1'b0, -1, 1'b0);
    wait_idle();
    chk("T6 word", got[got.size()-1], 64'h0003_0007_000B_000F);

    // Random jobs with random gaps and backpressure
    rdy_force = 1'b0;
    for (int j = 0; j < 25; j++) begin
      int n = $urandom_range(0, 13);
      ga.delete();
      gb.delete();
      for (int i = 0; i < n; i++) begin
        ga.push_back(DW'($urandom));
        gb.push_back(DW'($urandom));
      end
      run_job(n, (n >= 2) && ($urandom_range(0, 3) == 0), -1, 1'b1);
    end

    // Maximum length job
    ga.delete();
    gb.delete();
    for (int i = 0; i < 255; i++) begin
      ga.push_back(DW'($urandom));
      gb.push_back(DW'($urandom));
    end
    run_job(255, 1'b0, -1, 1'b0);
    wait_idle();

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
